sprite_collision_scanner: RTL and testbench

- Sequential, parametrised successor to the pairwise sprite collision check.
- On each start, reads one reference sprite, then every slot of the sprite register bank through a synchronous read port.
- Tests each enabled slot against the reference with a true axis-aligned bounding-box overlap, using configurable sprite size and edge mode.
- Returns a per-slot hit mask, hit count and lowest hit index to the game-logic/CPU register interface.

---
 rtl/sprite_collision_scanner.sv | 160 ++++++++++++++++
 tb/tb_sprite_collision_scanner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_collision_scanner.sv
// Sequential sprite collision scanner: latches one reference sprite from the bank,
// then sweeps every slot through a synchronous read port and accumulates AABB hits.
module sprite_collision_scanner #(
   parameter int NUM_SPRITES = 32,
   parameter int IDX_W       = 5,
   parameter int COORD_W     = 10,
   parameter int SPRITE_W    = 20,
   parameter int SPRITE_H    = 20,
   parameter bit EDGE_TOUCH  = 1'b0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [IDX_W-1:0]       ref_index,
   output logic [IDX_W-1:0]       rd_addr,
   input  logic [31:0]            rd_data,
   output logic                   busy,
   output logic                   done,
   output logic [NUM_SPRITES-1:0] hit_mask,
   output logic [IDX_W:0]         hit_count,
   output logic                   hit_any,
   output logic [IDX_W-1:0]       first_hit
);

   typedef enum logic [2:0] {
      S_IDLE, S_REF_ADDR, S_REF_WAIT, S_SCAN, S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       rd_addr_q, rd_addr_d;
   logic [IDX_W-1:0]       ref_idx_q, ref_idx_d;
   logic                   ref_en_q, ref_en_d;
   logic [COORD_W-1:0]     ref_x_q, ref_x_d;
   logic [COORD_W-1:0]     ref_y_q, ref_y_d;
   logic [IDX_W-1:0]       scan_idx_q, scan_idx_d;
   logic [NUM_SPRITES-1:0] hit_mask_q, hit_mask_d;
   logic [IDX_W:0]         hit_count_q, hit_count_d;
   logic                   hit_any_q, hit_any_d;
   logic [IDX_W-1:0]       first_hit_q, first_hit_d;

   logic                   slot_en;
   logic [COORD_W-1:0]     slot_x, slot_y;
   logic [COORD_W:0]       ref_x_end, ref_y_end, slot_x_end, slot_y_end;
   logic                   overlap_x, overlap_y, slot_hit;

   assign slot_en = rd_data[29];
   assign slot_x  = rd_data[19 +: COORD_W];
   assign slot_y  = rd_data[9 +: COORD_W];

   // One extra bit keeps right/bottom edges near the screen limit from wrapping.
   assign ref_x_end  = {1'b0, ref_x_q} + (COORD_W+1)'(SPRITE_W);
   assign ref_y_end  = {1'b0, ref_y_q} + (COORD_W+1)'(SPRITE_H);
   assign slot_x_end = {1'b0, slot_x}  + (COORD_W+1)'(SPRITE_W);
   assign slot_y_end = {1'b0, slot_y}  + (COORD_W+1)'(SPRITE_H);

   always_comb begin
      overlap_x = 1'b0;
      overlap_y = 1'b0;
      if (EDGE_TOUCH) begin
         overlap_x = (ref_x_end >= {1'b0, slot_x}) && (slot_x_end >= {1'b0, ref_x_q});
         overlap_y = (ref_y_end >= {1'b0, slot_y}) && (slot_y_end >= {1'b0, ref_y_q});
      end else begin
         overlap_x = (ref_x_end > {1'b0, slot_x}) && (slot_x_end > {1'b0, ref_x_q});
         overlap_y = (ref_y_end > {1'b0, slot_y}) && (slot_y_end > {1'b0, ref_y_q});
      end
   end

   assign slot_hit = slot_en && ref_en_q && (scan_idx_q != ref_idx_q) && overlap_x && overlap_y;

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      ref_idx_d   = ref_idx_q;
      ref_en_d    = ref_en_q;
      ref_x_d     = ref_x_q;
      ref_y_d     = ref_y_q;
      scan_idx_d  = scan_idx_q;
      hit_mask_d  = hit_mask_q;
      hit_count_d = hit_count_q;
      hit_any_d   = hit_any_q;
      first_hit_d = first_hit_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_REF_ADDR;
               rd_addr_d   = ref_index;
               ref_idx_d   = ref_index;
               hit_mask_d  = '0;
               hit_count_d = '0;
               hit_any_d   = 1'b0;
               first_hit_d = '0;
            end
         end
         S_REF_ADDR: begin
            state_d   = S_REF_WAIT;
            rd_addr_d = '0;
         end
         S_REF_WAIT: begin
            state_d    = S_SCAN;
            ref_en_d   = slot_en;
            ref_x_d    = slot_x;
            ref_y_d    = slot_y;
            rd_addr_d  = IDX_W'(1);
            scan_idx_d = '0;
         end
         S_SCAN: begin
            if (slot_hit) begin
               hit_mask_d[scan_idx_q] = 1'b1;
               hit_count_d = hit_count_q + (IDX_W+1)'(1);
               hit_any_d   = 1'b1;
               if (!hit_any_q) first_hit_d = scan_idx_q;
            end
            if (rd_addr_q != LAST_IDX) rd_addr_d = rd_addr_q + IDX_W'(1);
            if (scan_idx_q == LAST_IDX) state_d = S_DONE;
            else scan_idx_d = scan_idx_q + IDX_W'(1);
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rd_addr_q   <= '0;
         ref_idx_q   <= '0;
         ref_en_q    <= 1'b0;
         ref_x_q     <= '0;
         ref_y_q     <= '0;
         scan_idx_q  <= '0;
         hit_mask_q  <= '0;
         hit_count_q <= '0;
         hit_any_q   <= 1'b0;
         first_hit_q <= '0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         ref_idx_q   <= ref_idx_d;
         ref_en_q    <= ref_en_d;
         ref_x_q     <= ref_x_d;
         ref_y_q     <= ref_y_d;
         scan_idx_q  <= scan_idx_d;
         hit_mask_q  <= hit_mask_d;
         hit_count_q <= hit_count_d;
         hit_any_q   <= hit_any_d;
         first_hit_q <= first_hit_d;
      end
   end

   assign rd_addr   = rd_addr_q;
   assign busy      = (state_q == S_REF_ADDR) || (state_q == S_REF_WAIT) || (state_q == S_SCAN);
   assign done      = (state_q == S_DONE);
   assign hit_mask  = hit_mask_q;
   assign hit_count = hit_count_q;
   assign hit_any   = hit_any_q;
   assign first_hit = first_hit_q;

endmodule

// File: tb/tb_sprite_collision_scanner.sv
// Bench for sprite_collision_scanner: strict and edge-touch instances scan a shared
// sprite bank in lockstep; a monitor checks each done pulse against an interval model.
module tb_sprite_collision_scanner;

   localparam int N  = 32;
   localparam int IW = 5;
   localparam int SW = 20;
   localparam int SH = 20;

   typedef struct {
      logic [N-1:0]  mask;
      logic [IW:0]   count;
      logic          any;
      logic [IW-1:0] first;
      int            cyc;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset, start;
   logic [IW-1:0] ref_index;
   logic [31:0]   bank [N];

   logic [IW-1:0] rd_addr_a, rd_addr_b, first_hit_a, first_hit_b;
   logic [31:0]   rd_data_a, rd_data_b;
   logic          busy_a, busy_b, done_a, done_b, hit_any_a, hit_any_b;
   logic [N-1:0]  hit_mask_a, hit_mask_b;
   logic [IW:0]   hit_count_a, hit_count_b;

   exp_t exp_a_q[$];
   exp_t exp_b_q[$];
   int   errors = 0, checks = 0, cyc = 0, dones_a = 0;
   logic last_done_a = 1'b0, last_done_b = 1'b0;

   sprite_collision_scanner #(.NUM_SPRITES(N), .IDX_W(IW), .COORD_W(10),
      .SPRITE_W(SW), .SPRITE_H(SH), .EDGE_TOUCH(1'b0)) dut_a (
      .clock(clock), .reset(reset), .start(start), .ref_index(ref_index),
      .rd_addr(rd_addr_a), .rd_data(rd_data_a), .busy(busy_a), .done(done_a),
      .hit_mask(hit_mask_a), .hit_count(hit_count_a), .hit_any(hit_any_a),
      .first_hit(first_hit_a));

   sprite_collision_scanner #(.NUM_SPRITES(N), .IDX_W(IW), .COORD_W(10),
      .SPRITE_W(SW), .SPRITE_H(SH), .EDGE_TOUCH(1'b1)) dut_b (
      .clock(clock), .reset(reset), .start(start), .ref_index(ref_index),
      .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b), .done(done_b),
      .hit_mask(hit_mask_b), .hit_count(hit_count_b), .hit_any(hit_any_b),
      .first_hit(first_hit_b));

   // clock/reset block, cycle counter and synchronous bank read ports
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) begin
      rd_data_a <= bank[rd_addr_a];
      rd_data_b <= bank[rd_addr_b];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_slot(int idx, bit en, int x, int y);
      logic [31:0] r;
      logic [9:0]  xv, yv;
      r  = $urandom();
      xv = 10'(x);
      yv = 10'(y);
      bank[idx] = {r[31:30], en, xv, yv, r[8:0]};
   endtask

   task automatic clear_bank();
      for (int i = 0; i < N; i++) set_slot(i, 1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023));
   endtask

   // Reference model: intervals [x, x+W) intersect when max(start) < min(end).
   function automatic exp_t model(int ri, bit touch);
      exp_t e;
      int xr, yr, xs, ys, lo, hi, ylo, yhi;
      bit ren, ox, oy;
      e.mask = '0; e.count = '0; e.any = 1'b0; e.first = '0; e.cyc = 0;
      ren = bank[ri][29];
      xr  = int'(bank[ri][28:19]);
      yr  = int'(bank[ri][18:9]);
      for (int i = 0; i < N; i++) begin
         xs  = int'(bank[i][28:19]);
         ys  = int'(bank[i][18:9]);
         lo  = (xr > xs) ? xr : xs;
         hi  = (xr + SW < xs + SW) ? xr + SW : xs + SW;
         ylo = (yr > ys) ? yr : ys;
         yhi = (yr + SH < ys + SH) ? yr + SH : ys + SH;
         ox  = touch ? (lo <= hi) : (lo < hi);
         oy  = touch ? (ylo <= yhi) : (ylo < yhi);
         if (ren && bank[i][29] && i != ri && ox && oy) e.mask[i] = 1'b1;
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (e.mask[i]) begin
            e.count = e.count + 1'b1;
            e.any   = 1'b1;
            e.first = IW'(i);
         end
      end
      return e;
   endfunction

   // scoreboard monitor: pops one expectation per done pulse
   always @(negedge clock) begin
      exp_t e;
      if (done_a === 1'b1) begin
         check("a_done_single_cycle", last_done_a, 1'b0);
         if (exp_a_q.size() == 0) check("a_unexpected_done", done_a, 1'b0);
         else begin
            e = exp_a_q.pop_front();
            check("a_done_cycle", cyc, e.cyc);
            check("a_hit_mask", hit_mask_a, e.mask);
            check("a_hit_count", hit_count_a, e.count);
            check("a_hit_any", hit_any_a, e.any);
            check("a_first_hit", first_hit_a, e.first);
            check("a_busy_in_done", busy_a, 1'b0);
         end
         dones_a++;
      end
      if (done_b === 1'b1) begin
         check("b_done_single_cycle", last_done_b, 1'b0);
         if (exp_b_q.size() == 0) check("b_unexpected_done", done_b, 1'b0);
         else begin
            e = exp_b_q.pop_front();
            check("b_done_cycle", cyc, e.cyc);
            check("b_hit_mask", hit_mask_b, e.mask);
            check("b_hit_count", hit_count_b, e.count);
            check("b_hit_any", hit_any_b, e.any);
            check("b_first_hit", first_hit_b, e.first);
         end
      end
      last_done_a = (done_a === 1'b1);
      last_done_b = (done_b === 1'b1);
   end

   task automatic run_scan(int ri, bit repulse);
      exp_t ea, eb;
      int   e0, target;
      @(negedge clock);
      ref_index = IW'(ri);
      start     = 1'b1;
      e0        = cyc + 1;
      ea = model(ri, 1'b0); ea.cyc = e0 + N + 2; exp_a_q.push_back(ea);
      eb = model(ri, 1'b1); eb.cyc = e0 + N + 2; exp_b_q.push_back(eb);
      target = dones_a + 1;
      @(negedge clock);
      start     = 1'b0;
      ref_index = IW'($urandom_range(0, N - 1));
      check("busy_after_start", busy_a, 1'b1);
      check("count_cleared_at_start", hit_count_a, '0);
      check("mask_cleared_at_start", hit_mask_b, '0);
      check("rd_addr_is_ref", rd_addr_a, ri);
      @(negedge clock);
      check("rd_addr_zero_in_ref_wait", rd_addr_a, '0);
      if (repulse) begin
         repeat (3) @(negedge clock);
         ref_index = IW'($urandom_range(0, N - 1));
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      for (int k = 0; k < 60 && dones_a < target; k++) @(negedge clock);
      if (dones_a < target) check("done_timeout", 1'b0, 1'b1);
      repeat (3) @(negedge clock);
      check("hold_mask_after_done", hit_mask_a, ea.mask);
      check("hold_count_after_done", hit_count_b, eb.count);
      check("rd_addr_holds_last", rd_addr_a, N - 1);
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_busy"}, {busy_a, busy_b}, 2'b00);
      check({tag, "_done"}, {done_a, done_b}, 2'b00);
      check({tag, "_hit_mask"}, {hit_mask_a, hit_mask_b}, '0);
      check({tag, "_hit_count"}, {hit_count_a, hit_count_b}, '0);
      check({tag, "_hit_any"}, {hit_any_a, hit_any_b}, 2'b00);
      check({tag, "_first_hit"}, {first_hit_a, first_hit_b}, '0);
      check({tag, "_rd_addr"}, {rd_addr_a, rd_addr_b}, '0);
   endtask

   task automatic load_basic_bank();
      clear_bank();
      set_slot(0, 1'b1, 100, 100);
      set_slot(3, 1'b1, 110, 115);
      set_slot(7, 1'b1, 120, 100);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; ref_index = '0;
      clear_bank();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      check_all_zero("idle_after_reset");

      load_basic_bank();
      run_scan(0, 1'b0);
      check("basic_mask_strict", hit_mask_a, 32'h0000_0008);
      check("basic_mask_touch", hit_mask_b, 32'h0000_0088);
      check("basic_first_touch", first_hit_b, 3);

      clear_bank();
      set_slot(5, 1'b1, 1010, 0);
      set_slot(9, 1'b1, 1020, 0);
      run_scan(5, 1'b0);
      check("right_edge_hit", hit_mask_a, 32'h0000_0200);
      set_slot(5, 1'b1, 5, 0);
      set_slot(9, 1'b1, 1015, 0);
      run_scan(5, 1'b0);
      check("no_wrap_false_hit", {hit_mask_a, hit_mask_b}, '0);

      clear_bank();
      set_slot(0, 1'b1, 100, 100);
      set_slot(2, 1'b0, 105, 105);
      set_slot(4, 1'b1, 105, 105);
      run_scan(0, 1'b0);
      check("disabled_slot_ignored", hit_mask_a, 32'h0000_0010);

      for (int i = 0; i < N; i++) set_slot(i, 1'b1, 100, 100);
      set_slot(6, 1'b0, 100, 100);
      run_scan(6, 1'b0);
      check("ref_disabled_no_hits", {hit_mask_a, hit_mask_b}, '0);

      load_basic_bank();
      run_scan(0, 1'b1);

      // abort a scan at E10; no done may follow
      @(negedge clock);
      ref_index = '0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      check("busy_before_abort", busy_a, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      check_all_zero("after_mid_scan_reset");
      reset = 1'b0;
      repeat (45) @(negedge clock);
      check("no_done_after_abort", exp_a_q.size(), 0);
      run_scan(0, 1'b0);

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < N; i++) begin
            if (t % 2 == 0)
               set_slot(i, ($urandom_range(0, 3) != 0), $urandom_range(60, 140), $urandom_range(60, 140));
            else
               set_slot(i, ($urandom_range(0, 3) != 0), $urandom_range(980, 1023), $urandom_range(0, 60));
         end
         run_scan($urandom_range(0, N - 1), 1'b0);
      end

      repeat (5) @(negedge clock);
      check("queue_a_drained", exp_a_q.size(), 0);
      check("queue_b_drained", exp_b_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
